// File: rtl/serial_incrementer_ctrl_pkg.sv
// ============================================================================
// Module   : serial_incrementer_ctrl_pkg
// Desc     : State encoding and shared constants for the bit-serial incrementer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_incrementer_ctrl_pkg;

    localparam int C_DEFAULT_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_incrementer_ctrl_inc_bit_slice.sv
// ============================================================================
// Module   : inc_bit_slice
// Desc     : One-bit half-adder slice (bit + carry) built only from NAND cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inc_bit_slice (
    input  logic bit_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);

    logic w_n1;
    logic w_n2;
    logic w_n3;

    // Classic four-NAND XOR; the shared first NAND doubles as the inverted AND
    assign w_n1    = ~(bit_i & carry_i);
    assign w_n2    = ~(bit_i & w_n1);
    assign w_n3    = ~(carry_i & w_n1);
    assign sum_o   = ~(w_n2 & w_n3);
    assign carry_o = ~w_n1;

endmodule

`default_nettype wire

// File: rtl/serial_incrementer_ctrl.sv
// ============================================================================
// Module   : serial_incrementer_ctrl
// Desc     : Bit-serial +1 sequencer reusing one adder slice, with start/ready/done
//            handshake and optional early exit once the carry dies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_incrementer_ctrl
    import serial_incrementer_ctrl_pkg::*;
#(
    parameter int WIDTH      = C_DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic [CW-1:0]    cycles
);

    localparam int                c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

    state_e               r_state_q;
    state_e               w_state_d;
    logic [WIDTH:0]       r_result_q;
    logic [WIDTH:0]       w_result_d;
    logic                 r_carry_q;
    logic                 w_carry_d;
    logic [c_IDX_W-1:0]   r_idx_q;
    logic [c_IDX_W-1:0]   w_idx_d;
    logic [CW-1:0]        r_cycles_q;
    logic [CW-1:0]        w_cycles_d;

    logic                 w_bit;
    logic                 w_sum;
    logic                 w_cout;

    assign w_bit = r_result_q[r_idx_q];

    inc_bit_slice u_slice (
        .bit_i   (w_bit),
        .carry_i (r_carry_q),
        .sum_o   (w_sum),
        .carry_o (w_cout)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_idx_d    = r_idx_q;
        w_cycles_d = r_cycles_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_result_d = {1'b0, operand};
                    w_carry_d  = 1'b1;
                    w_idx_d    = '0;
                    w_cycles_d = '0;
                    w_state_d  = S_RUN;
                end else begin
                    w_state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                w_result_d[r_idx_q] = w_sum;
                w_carry_d           = w_cout;
                w_idx_d             = r_idx_q + c_IDX_W'(1);
                w_cycles_d          = r_cycles_q + CW'(1);
                if (r_idx_q == c_LAST_IDX) begin
                    w_result_d[WIDTH] = w_cout;
                    w_state_d         = S_DONE;
                end else if (EARLY_EXIT && !w_cout) begin
                    // Bits above idx are unaffected once the carry is gone
                    w_state_d = S_DONE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_idx_q    <= '0;
            r_cycles_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_idx_q    <= w_idx_d;
            r_cycles_q <= w_cycles_d;
        end
    end

    assign ready  = (r_state_q == S_IDLE) || (r_state_q == S_DONE);
    assign busy   = (r_state_q == S_RUN);
    assign done   = (r_state_q == S_DONE);
    assign result = r_result_q;
    assign cycles = r_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_incrementer_ctrl.sv
// ============================================================================
// Module   : tb_serial_incrementer_ctrl
// Desc     : Self-checking bench driving one EARLY_EXIT=0 and one EARLY_EXIT=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_incrementer_ctrl;

    typedef struct {
        logic [16:0] res;
        logic [4:0]  cyc;
        int          t;
    } exp_t;

    typedef struct {
        int          d;
        logic [15:0] op;
        logic [16:0] res;
        logic [4:0]  cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start   [2];
    logic [15:0] operand [2];
    logic        ready   [2];
    logic        busy    [2];
    logic        done    [2];
    logic [16:0] result  [2];
    logic [4:0]  cycles  [2];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   busy_cnt  [2];
    logic prev_done [2];

    always #5 clk = ~clk;

    serial_incrementer_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut_ee0 (
        .clk(clk), .rst(rst), .start(start[0]), .operand(operand[0]),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]),
        .result(result[0]), .cycles(cycles[0])
    );

    serial_incrementer_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut_ee1 (
        .clk(clk), .rst(rst), .start(start[1]), .operand(operand[1]),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]),
        .result(result[1]), .cycles(cycles[1])
    );

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t pop(input int d);
        if (d == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    task automatic push(input int d, input logic [16:0] r, input logic [4:0] c, input int t);
        exp_t e;
        e.res = r; e.cyc = c; e.t = t;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    function automatic int tones(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (!v[i]) break;
            n++;
        end
        return n;
    endfunction

    // Cycle counter and scoreboard monitor
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb0.delete();
            sb1.delete();
            for (int d = 0; d < 2; d++) begin
                busy_cnt[d]  = 0;
                prev_done[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d]) busy_cnt[d]++;
                if (done[d]) begin
                    exp_t e;
                    check("done_width", d, 32'(prev_done[d]), 32'd0);
                    if (qsize(d) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done dut%0d: got done=1 required no pending op (cycle %0d)", d, cyc);
                    end else begin
                        e = pop(d);
                        check("result", d, 32'(result[d]), 32'(e.res));
                        check("cycles", d, 32'(cycles[d]), 32'(e.cyc));
                        check("latency", d, 32'(cyc - e.t), 32'(e.cyc) + 32'd1);
                        check("busy_len", d, 32'(busy_cnt[d]), 32'(e.cyc));
                    end
                    busy_cnt[d] = 0;
                end
                prev_done[d] = done[d];
            end
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_start", d, 32'(ready[d]), 32'd1);
    endtask

    task automatic issue(input int d, input logic [15:0] op, input logic [16:0] r, input logic [4:0] c);
        @(posedge clk); #1;
        wait_ready(d);
        start[d]   = 1'b1;
        operand[d] = op;
        push(d, r, c, cyc);
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending ops required 0", sb0.size(), sb1.size());
            sb0.delete();
            sb1.delete();
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [15:0] op;
        int          k;
        int          n;
        logic [4:0]  c1;
        logic [4:0]  c2;
        int          msk;

        vecs[0] = '{1, 16'h0000, 17'h00001, 5'd1};
        vecs[1] = '{1, 16'h00FF, 17'h00100, 5'd9};
        vecs[2] = '{1, 16'hFFFF, 17'h10000, 5'd16};
        vecs[3] = '{0, 16'hFFFF, 17'h10000, 5'd16};
        vecs[4] = '{0, 16'h1234, 17'h01235, 5'd16};
        vecs[5] = '{1, 16'h1234, 17'h01235, 5'd1};
        vecs[6] = '{1, 16'h7FFF, 17'h08000, 5'd16};
        vecs[7] = '{0, 16'h0000, 17'h00001, 5'd16};
        vecs[8] = '{1, 16'h0007, 17'h00008, 5'd4};
        vecs[9] = '{1, 16'hFFFE, 17'h0FFFF, 5'd1};

        for (int d = 0; d < 2; d++) begin
            start[d]   = 1'b0;
            operand[d] = 16'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", d, 32'(ready[d]), 32'd1);
            check("rst_busy", d, 32'(busy[d]), 32'd0);
            check("rst_done", d, 32'(done[d]), 32'd0);
            check("rst_result", d, 32'(result[d]), 32'd0);
            check("rst_cycles", d, 32'(cycles[d]), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].d, vecs[i].op, vecs[i].res, vecs[i].cyc);
            drain();
            repeat (2) @(negedge clk);
            check("held_result", vecs[i].d, 32'(result[vecs[i].d]), 32'(vecs[i].res));
            check("held_cycles", vecs[i].d, 32'(cycles[vecs[i].d]), 32'(vecs[i].cyc));
        end

        // start held through RUN: only the DONE-cycle acceptance may count
        for (int d = 0; d < 2; d++) begin
            c1 = (d == 1) ? 5'd1 : 5'd16;
            c2 = (d == 1) ? 5'd4 : 5'd16;
            @(posedge clk); #1;
            start[d]   = 1'b1;
            operand[d] = 16'h1234;
            k = cyc;
            push(d, 17'h01235, c1, k);
            @(posedge clk); #1;
            operand[d] = 16'h0007;
            push(d, 17'h00008, c2, k + int'(c1) + 1);
            n = 0;
            while (qsize(d) == 2 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            start[d] = 1'b0;
            drain();
        end

        // reset in the fifth RUN cycle discards the operation
        @(posedge clk); #1;
        start[1]   = 1'b1;
        operand[1] = 16'h7FFF;
        push(1, 17'h08000, 5'd16, cyc);
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 1, 32'(ready[1]), 32'd1);
        check("midrst_busy", 1, 32'(busy[1]), 32'd0);
        check("midrst_done", 1, 32'(done[1]), 32'd0);
        check("midrst_result", 1, 32'(result[1]), 32'd0);
        check("midrst_cycles", 1, 32'(cycles[1]), 32'd0);
        repeat (25) @(negedge clk);
        issue(1, 16'h0001, 17'h00002, 5'd2);
        drain();

        for (int i = 0; i < 1000; i++) begin
            op = 16'($urandom);
            if (i % 3 == 0) begin
                msk = (1 << $urandom_range(0, 16)) - 1;
                op  = op | msk[15:0];
            end
            @(posedge clk); #1;
            wait_ready(0);
            wait_ready(1);
            start[0]   = 1'b1;
            start[1]   = 1'b1;
            operand[0] = op;
            operand[1] = op;
            push(0, {1'b0, op} + 17'd1, 5'd16, cyc);
            push(1, {1'b0, op} + 17'd1, (tones(op) >= 15) ? 5'd16 : 5'(tones(op) + 1), cyc);
            @(posedge clk); #1;
            start[0] = 1'b0;
            start[1] = 1'b0;
            drain();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
